// File: rtl/alt_vipvfr131_common_control_packet_encoder.sv
// alt_vipvfr131_common_control_packet_encoder: wraps raw sop/eop pixels into a VIP stream with optional control packet and video header
module alt_vipvfr131_common_control_packet_encoder #(
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int SYMBOLS_PER_BEAT = 3
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    output logic                                        din_ready,
    input  logic                                        din_valid,
    input  logic                                        din_sop,
    input  logic                                        din_eop,
    input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] din_data,
    input  logic                                        dout_ready,
    output logic                                        dout_valid,
    output logic                                        dout_sop,
    output logic                                        dout_eop,
    output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
    input  logic [15:0]                                 width,
    input  logic [15:0]                                 height,
    input  logic [3:0]                                  interlaced,
    input  logic                                        ctrl_enable,
    output logic                                        frame_done
);
    localparam int B  = BITS_PER_SYMBOL;
    localparam int S  = SYMBOLS_PER_BEAT;
    localparam int W  = B * S;
    localparam int NB = (9 + S - 1) / S;
    typedef enum logic [2:0] {IDLE, CTRL_HDR, CTRL_DATA, VID_HDR, VIDEO} state_t;
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [15:0] width_q, height_q;
    logic [3:0] interlaced_q;
    logic fd_q, fd_d, latch;
    logic ready_c, valid_c, sop_c, eop_c;
    logic [W-1:0] data_c, ctrl_data;
    logic [35:0] nibs;
    assign nibs = {width_q, height_q, interlaced_q};
    // nibble k of the control payload lands in the low 4 bits of symbol k%S of beat k/S
    always_comb begin
        ctrl_data = '0;
        for (int s = 0; s < S; s++)
            if (int'(cnt_q) * S + s < 9)
                ctrl_data[s*B +: 4] = nibs[35 - 4*(int'(cnt_q) * S + s) -: 4];
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fd_d    = 1'b0;
        latch   = 1'b0;
        ready_c = 1'b0;
        valid_c = 1'b0;
        sop_c   = 1'b0;
        eop_c   = 1'b0;
        data_c  = '0;
        case (state_q)
            IDLE: begin
                ready_c = ~din_sop;
                if (din_valid && din_sop) begin
                    latch   = 1'b1;
                    state_d = ctrl_enable ? CTRL_HDR : VID_HDR;
                end
            end
            CTRL_HDR: begin
                valid_c     = 1'b1;
                sop_c       = 1'b1;
                data_c[3:0] = 4'hF;
                if (dout_ready) state_d = CTRL_DATA;
            end
            CTRL_DATA: begin
                valid_c = 1'b1;
                data_c  = ctrl_data;
                eop_c   = cnt_q == 4'(NB - 1);
                if (dout_ready) begin
                    cnt_d   = eop_c ? 4'd0 : cnt_q + 4'd1;
                    state_d = eop_c ? VID_HDR : CTRL_DATA;
                end
            end
            VID_HDR: begin
                valid_c = 1'b1;
                sop_c   = 1'b1;
                if (dout_ready) state_d = VIDEO;
            end
            VIDEO: begin
                valid_c = din_valid;
                ready_c = dout_ready;
                data_c  = din_data;
                eop_c   = din_eop;
                if (din_valid && dout_ready && din_eop) begin
                    fd_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            width_q      <= 16'd640;
            height_q     <= 16'd480;
            interlaced_q <= '0;
            fd_q         <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fd_q    <= fd_d;
            if (latch) begin
                width_q      <= width;
                height_q     <= height;
                interlaced_q <= interlaced;
            end
        end
    end
    // outputs are forced quiet while reset is held, independent of the clock
    assign din_ready  = rst_n & ready_c;
    assign dout_valid = rst_n & valid_c;
    assign dout_sop   = rst_n & sop_c;
    assign dout_eop   = rst_n & eop_c;
    assign dout_data  = {W{rst_n}} & data_c;
    assign frame_done = fd_q;
endmodule

// File: tb/tb_alt_vipvfr131_common_control_packet_encoder.sv
// tb_alt_vipvfr131_common_control_packet_encoder: randomized scenarios against a stream-level model of the encoder
module tb_alt_vipvfr131_common_control_packet_encoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic din_ready, din_valid = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
    logic [23:0] din_data = '0;
    logic dout_ready = 1'b1, dout_valid, dout_sop, dout_eop;
    logic [23:0] dout_data;
    logic [15:0] width = 16'd800, height = 16'd600;
    logic [3:0] interlaced = 4'd0;
    logic ctrl_enable = 1'b1;
    logic frame_done;
    logic d1_din_ready, d1_din_valid = 1'b0, d1_din_sop = 1'b0, d1_din_eop = 1'b0;
    logic [7:0] d1_din_data = '0;
    logic d1_dout_valid, d1_dout_sop, d1_dout_eop, d1_frame_done;
    logic [7:0] d1_dout_data;

    alt_vipvfr131_common_control_packet_encoder #(.BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(3)) dut (
        .clk(clk), .rst_n(rst_n), .din_ready(din_ready), .din_valid(din_valid), .din_sop(din_sop),
        .din_eop(din_eop), .din_data(din_data), .dout_ready(dout_ready), .dout_valid(dout_valid),
        .dout_sop(dout_sop), .dout_eop(dout_eop), .dout_data(dout_data), .width(width), .height(height),
        .interlaced(interlaced), .ctrl_enable(ctrl_enable), .frame_done(frame_done));

    alt_vipvfr131_common_control_packet_encoder #(.BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .din_ready(d1_din_ready), .din_valid(d1_din_valid), .din_sop(d1_din_sop),
        .din_eop(d1_din_eop), .din_data(d1_din_data), .dout_ready(dout_ready), .dout_valid(d1_dout_valid),
        .dout_sop(d1_dout_sop), .dout_eop(d1_dout_eop), .dout_data(d1_dout_data), .width(width), .height(height),
        .interlaced(interlaced), .ctrl_enable(ctrl_enable), .frame_done(d1_frame_done));

    always #5 clk = ~clk;

    typedef struct { logic sop; logic eop; logic [23:0] data; logic pix; } exp_t;
    typedef struct { logic sop; logic eop; logic [23:0] data; logic hi; logic ne; int c; } got_t;
    exp_t exp_q[$];
    got_t got_q[$];
    int fd_q[$];
    logic [23:0] pix_a[16];
    int cyc = 0, unstable = 0, sop_c = 0, n_tests = 0, n_fails = 0;
    logic rand_mode = 1'b0;
    logic cur_hi = 1'b0, cur_ne = 1'b0, held_v = 1'b0;
    logic [25:0] held = '0;

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1;
        dout_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // observer: records every transferred output beat with handshake flags seen while it was offered
    initial forever begin
        got_t g;
        @(negedge clk);
        if (!rst_n) begin
            cur_hi = 1'b0; cur_ne = 1'b0; held_v = 1'b0;
        end else begin
            if (dout_valid) begin
                if (held_v && {dout_sop, dout_eop, dout_data} !== held) unstable++;
                cur_hi |= din_ready;
                cur_ne |= (din_ready != dout_ready);
                if (dout_ready) begin
                    g.sop = dout_sop; g.eop = dout_eop; g.data = dout_data;
                    g.hi = cur_hi; g.ne = cur_ne; g.c = cyc;
                    got_q.push_back(g);
                    cur_hi = 1'b0; cur_ne = 1'b0; held_v = 1'b0;
                end else begin
                    held_v = 1'b1;
                    held = {dout_sop, dout_eop, dout_data};
                end
            end
            if (frame_done) fd_q.push_back(cyc);
        end
    end

    function automatic logic [3:0] nib(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il, input int k);
        logic [15:0] v;
        v = (k < 4) ? w : h;
        return (k == 8) ? il : v[4*(3 - k % 4) +: 4];
    endfunction

    task automatic model(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il, input logic ce, input int n);
        exp_t e;
        if (ce) begin
            e.sop = 1'b1; e.eop = 1'b0; e.data = 24'h00000F; e.pix = 1'b0;
            exp_q.push_back(e);
            for (int b = 0; b < 3; b++) begin
                e.sop = 1'b0; e.eop = (b == 2); e.data = '0;
                for (int s = 0; s < 3; s++) e.data |= 24'(nib(w, h, il, b * 3 + s)) << (8 * s);
                exp_q.push_back(e);
            end
        end
        e.sop = 1'b1; e.eop = 1'b0; e.data = '0; e.pix = 1'b0;
        exp_q.push_back(e);
        for (int i = 0; i < n; i++) begin
            e.sop = 1'b0; e.eop = (i == n - 1); e.data = pix_a[i]; e.pix = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic clr();
        got_q.delete(); exp_q.delete(); fd_q.delete(); unstable = 0;
    endtask

    task automatic gen_pix(input int n);
        for (int i = 0; i < n; i++) pix_a[i] = 24'($urandom);
    endtask

    task automatic drive_frame(input int n, input logic mid_sop);
        logic ok;
        int w;
        for (int i = 0; i < n; i++) begin
            din_valid = 1'b1;
            din_sop = (i == 0) || (mid_sop && 1'($urandom_range(0, 1)));
            din_eop = (i == n - 1);
            din_data = pix_a[i];
            w = 0;
            ok = 1'b0;
            while (!ok && w < 300) begin
                @(negedge clk);
                if (i == 0 && w == 0) sop_c = cyc;
                ok = din_ready;
                @(posedge clk);
                #1;
                w++;
            end
            n_tests++;
            if (!ok) begin
                n_fails++;
                $display("FAIL drive_timeout pixel %0d got no din_ready within %0d cycles, required acceptance", i, w);
            end
        end
        din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({din_ready, dout_valid, dout_sop, dout_eop, dout_data, frame_done} !== '0) begin
            n_fails++;
            $display("FAIL reset_outputs got rdy%b v%b s%b e%b d%h fd%b required all 0",
                     din_ready, dout_valid, dout_sop, dout_eop, dout_data, frame_done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({din_ready, dout_valid, frame_done} !== 3'b100) begin
            n_fails++;
            $display("FAIL reset_idle got rdy%b v%b fd%b required rdy1 v0 fd0", din_ready, dout_valid, frame_done);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ctrl_s3();
        clr();
        width = 16'h0320; height = 16'h0258; interlaced = 4'h0; ctrl_enable = 1'b1;
        gen_pix(4);
        model(width, height, interlaced, 1'b1, 4);
        drive_frame(4, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fails++;
            $display("FAIL ctrl_s3 beat_count got %0d required %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_tests++;
            if ({got_q[i].sop, got_q[i].eop, got_q[i].data, exp_q[i].pix ? got_q[i].ne : got_q[i].hi} !==
                {exp_q[i].sop, exp_q[i].eop, exp_q[i].data, 1'b0}) begin
                n_fails++;
                $display("FAIL ctrl_s3 beat %0d got s%b e%b %h hi%b ne%b required s%b e%b %h", i, got_q[i].sop,
                         got_q[i].eop, got_q[i].data, got_q[i].hi, got_q[i].ne, exp_q[i].sop, exp_q[i].eop, exp_q[i].data);
            end
        end
        if (got_q.size() == 9) begin
            n_tests++;
            if (got_q[0].c != sop_c + 1 || got_q[4].c != sop_c + 5 || got_q[5].c != sop_c + 6 || got_q[8].c != sop_c + 9) begin
                n_fails++;
                $display("FAIL ctrl_s3 latency got hdr@+%0d vhdr@+%0d pix0@+%0d last@+%0d required +1 +5 +6 +9",
                         got_q[0].c - sop_c, got_q[4].c - sop_c, got_q[5].c - sop_c, got_q[8].c - sop_c);
            end
            n_tests++;
            if (fd_q.size() != 1 || (fd_q.size() == 1 && fd_q[0] != got_q[8].c + 1)) begin
                n_fails++;
                $display("FAIL ctrl_s3 frame_done got %0d pulses required one pulse at cycle %0d", fd_q.size(), got_q[8].c + 1);
            end
        end
    endtask

    task automatic test_s1();
        logic [7:0] s1_exp[11];
        s1_exp = '{8'h0F, 8'h0, 8'h3, 8'h2, 8'h0, 8'h0, 8'h2, 8'h5, 8'h8, 8'h0, 8'h0};
        width = 16'h0320; height = 16'h0258; interlaced = 4'h0; ctrl_enable = 1'b1;
        d1_din_valid = 1'b1; d1_din_sop = 1'b1; d1_din_eop = 1'b0; d1_din_data = 8'hA5;
        @(posedge clk);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            n_tests++;
            if ({d1_dout_valid, d1_dout_sop, d1_dout_eop, d1_dout_data, d1_din_ready} !==
                {1'b1, i == 0 || i == 10, i == 9, s1_exp[i], 1'b0}) begin
                n_fails++;
                $display("FAIL s1_beat %0d got v%b s%b e%b %h rdy%b required v1 s%b e%b %h rdy0", i, d1_dout_valid,
                         d1_dout_sop, d1_dout_eop, d1_dout_data, d1_din_ready, i == 0 || i == 10, i == 9, s1_exp[i]);
            end
        end
        @(posedge clk);
        #1;
        d1_din_sop = 1'b1; d1_din_eop = 1'b1; d1_din_data = 8'h3C;
        @(negedge clk);
        n_tests++;
        if ({d1_dout_valid, d1_dout_sop, d1_dout_eop, d1_dout_data, d1_din_ready} !== {3'b101, 8'h3C, 1'b1}) begin
            n_fails++;
            $display("FAIL s1_single_pixel got v%b s%b e%b %h rdy%b required v1 s0 e1 3c rdy1",
                     d1_dout_valid, d1_dout_sop, d1_dout_eop, d1_dout_data, d1_din_ready);
        end
        @(posedge clk);
        #1;
        d1_din_valid = 1'b0; d1_din_sop = 1'b0; d1_din_eop = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({d1_frame_done, d1_dout_valid} !== 2'b10) begin
            n_fails++;
            $display("FAIL s1_frame_done got fd%b v%b required fd1 v0", d1_frame_done, d1_dout_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_no_ctrl();
        clr();
        width = 16'($urandom); height = 16'($urandom); interlaced = 4'($urandom); ctrl_enable = 1'b0;
        gen_pix(1);
        model(width, height, interlaced, 1'b0, 1);
        drive_frame(1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fails++;
            $display("FAIL no_ctrl beat_count got %0d required %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_tests++;
            if ({got_q[i].sop, got_q[i].eop, got_q[i].data, exp_q[i].pix ? got_q[i].ne : got_q[i].hi} !==
                {exp_q[i].sop, exp_q[i].eop, exp_q[i].data, 1'b0}) begin
                n_fails++;
                $display("FAIL no_ctrl beat %0d got s%b e%b %h required s%b e%b %h", i, got_q[i].sop,
                         got_q[i].eop, got_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].data);
            end
        end
        if (got_q.size() == 2) begin
            n_tests++;
            if (got_q[0].c != sop_c + 1 || got_q[1].c != sop_c + 2 || fd_q.size() != 1) begin
                n_fails++;
                $display("FAIL no_ctrl latency got hdr@+%0d pix@+%0d fd_pulses %0d required +1 +2 1",
                         got_q[0].c - sop_c, got_q[1].c - sop_c, fd_q.size());
            end
        end
    endtask

    task automatic test_random_ready();
        for (int r = 0; r < 4; r++) begin
            int n;
            clr();
            n = $urandom_range(1, 8);
            width = 16'($urandom); height = 16'($urandom); interlaced = 4'($urandom); ctrl_enable = 1'b1;
            gen_pix(n);
            model(width, height, interlaced, 1'b1, n);
            rand_mode = 1'b1;
            drive_frame(n, 1'b1);
            rand_mode = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            n_tests++;
            if (got_q.size() != exp_q.size() || unstable != 0) begin
                n_fails++;
                $display("FAIL rand_ready run %0d got %0d beats %0d unstable holds required %0d beats 0 unstable",
                         r, got_q.size(), unstable, exp_q.size());
            end
            foreach (exp_q[i]) if (i < got_q.size()) begin
                n_tests++;
                if ({got_q[i].sop, got_q[i].eop, got_q[i].data, exp_q[i].pix ? got_q[i].ne : got_q[i].hi} !==
                    {exp_q[i].sop, exp_q[i].eop, exp_q[i].data, 1'b0}) begin
                    n_fails++;
                    $display("FAIL rand_ready run %0d beat %0d got s%b e%b %h hi%b ne%b required s%b e%b %h", r, i,
                             got_q[i].sop, got_q[i].eop, got_q[i].data, got_q[i].hi, got_q[i].ne,
                             exp_q[i].sop, exp_q[i].eop, exp_q[i].data);
                end
            end
            n_tests++;
            if (fd_q.size() != 1 || (got_q.size() > 0 && fd_q.size() == 1 && fd_q[0] != got_q[$].c + 1)) begin
                n_fails++;
                $display("FAIL rand_ready run %0d frame_done got %0d pulses required 1 after eop", r, fd_q.size());
            end
        end
    endtask

    task automatic test_stray();
        int acc;
        clr();
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            din_valid = 1'b1; din_sop = 1'b0; din_eop = 1'($urandom_range(0, 1)); din_data = 24'($urandom);
            @(negedge clk);
            if (din_ready) acc++;
            @(posedge clk);
            #1;
        end
        din_valid = 1'b0; din_eop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (acc != 3 || got_q.size() != 0 || fd_q.size() != 0) begin
            n_fails++;
            $display("FAIL stray accepted %0d dout_beats %0d fd %0d required 3 0 0", acc, got_q.size(), fd_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int sop1, n1, n2, w2;
        clr();
        n1 = $urandom_range(1, 5);
        n2 = $urandom_range(1, 5);
        width = 16'($urandom); height = 16'($urandom); interlaced = 4'($urandom); ctrl_enable = 1'b1;
        w2 = int'(~width);
        gen_pix(n1);
        model(width, height, interlaced, 1'b1, n1);
        fork
            drive_frame(n1, 1'b0);
            begin
                repeat (2) @(posedge clk);
                #1;
                width = 16'(w2); ctrl_enable = 1'b0;
            end
        join
        sop1 = sop_c;
        gen_pix(n2);
        model(width, height, interlaced, 1'b0, n2);
        drive_frame(n2, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fails++;
            $display("FAIL b2b beat_count got %0d required %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_tests++;
            if ({got_q[i].sop, got_q[i].eop, got_q[i].data, exp_q[i].pix ? got_q[i].ne : got_q[i].hi} !==
                {exp_q[i].sop, exp_q[i].eop, exp_q[i].data, 1'b0}) begin
                n_fails++;
                $display("FAIL b2b beat %0d got s%b e%b %h required s%b e%b %h", i, got_q[i].sop,
                         got_q[i].eop, got_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].data);
            end
        end
        if (got_q.size() == exp_q.size()) begin
            n_tests++;
            if (sop_c != got_q[4 + n1].c + 1 || got_q[5 + n1].c != sop_c + 1 || got_q[0].c != sop1 + 1 || fd_q.size() != 2) begin
                n_fails++;
                $display("FAIL b2b timing got sop2@%0d eop1@%0d hdr2@%0d fd %0d required sop2=eop1+1 hdr2=sop2+1 fd 2",
                         sop_c, got_q[4 + n1].c, got_q[5 + n1].c, fd_q.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        clr();
        width = 16'h0320; height = 16'h0258; interlaced = 4'h0; ctrl_enable = 1'b1;
        din_valid = 1'b1; din_sop = 1'b1; din_data = 24'h123456;
        repeat (3) @(posedge clk);
        #2;
        n_tests++;
        if ({dout_valid, dout_sop, dout_eop, dout_data} !== {3'b100, 24'h020000}) begin
            n_fails++;
            $display("FAIL rst_mid pre got v%b s%b e%b %h required ctrl beat 1 v1 s0 e0 020000",
                     dout_valid, dout_sop, dout_eop, dout_data);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({din_ready, dout_valid, dout_sop, dout_eop, dout_data} !== '0) begin
            n_fails++;
            $display("FAIL rst_mid async got rdy%b v%b s%b e%b %h required all 0",
                     din_ready, dout_valid, dout_sop, dout_eop, dout_data);
        end
        din_valid = 1'b0; din_sop = 1'b0; width = 16'd320;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clr();
        gen_pix(2);
        model(width, height, interlaced, 1'b1, 2);
        drive_frame(2, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (got_q.size() != exp_q.size() || (got_q.size() > 1 && got_q[1].data !== 24'h040100)) begin
            n_fails++;
            $display("FAIL rst_mid fresh got %0d beats first data %h required %0d beats 040100",
                     got_q.size(), got_q.size() > 1 ? got_q[1].data : 24'h0, exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_tests++;
            if ({got_q[i].sop, got_q[i].eop, got_q[i].data} !== {exp_q[i].sop, exp_q[i].eop, exp_q[i].data}) begin
                n_fails++;
                $display("FAIL rst_mid beat %0d got s%b e%b %h required s%b e%b %h", i, got_q[i].sop,
                         got_q[i].eop, got_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ctrl_s3();
        test_s1();
        test_no_ctrl();
        test_random_ready();
        test_stray();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation exceeded time bound");
        $fatal(1, "timeout");
    end
endmodule
